sram_readout_ctrl: RTL and testbench
====================================

Name: sram_readout_ctrl

Overview:
- Read-back counterpart of the serial SRAM loader.
- Serially receives a start address and a word count, then issues SRAM read cycles with auto-incrementing address.
- Shifts each fetched word out serially, LSB first, with a valid strobe, and raises RDY when the burst completes.
- Sits between the external scan pins and the instruction/data SRAM; used to dump memory contents for checking.

Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM word width.
- MEMORY_ADDR_WIDTH, 9, SRAM address width.
- CNT_WIDTH, 4, width of burst length field; burst = count+1 words.
- LOAD_BITS, MEMORY_ADDR_WIDTH+CNT_WIDTH, serial command frame length (derived).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-high.
- SI  in  1  serial command input, LSB first.
- LOAD_N  in  1  active-low start/command strobe.
- PI  in  MEMORY_DATA_WIDTH  read data from SRAM.
- SO  out  1  serial data output.
- SO_VLD  out  1  high while SO carries a valid data bit.
- RDY  out  1  burst complete.
- CEN  out  1  SRAM chip enable, low active.
- WEN  out  1  SRAM write enable, low active; always 1 (read only).
- A  out  MEMORY_ADDR_WIDTH  SRAM address.

Behaviour:
- Reset: RST high at a posedge forces state IDLE and clears the shift/data registers, address and count. Outputs: SO=0, SO_VLD=0, RDY=0, A=0.
- Reset for CEN/WEN: CEN and WEN are forced to 1 at the next negedge while RST is high.
- Reset priority: RST overrides every state, including mid-LOAD and mid-SHIFT. No partial frame survives.
- States: IDLE, LOAD, READ, WAIT, SHIFT, DONE.
- IDLE: LOAD_N sampled 0 -> LOAD; otherwise stay in IDLE.
- LOAD: exactly LOAD_BITS cycles. Each posedge shifts {SI, cmd[LOAD_BITS-1:1]}. The first bit is sampled at the first posedge in LOAD.
- Frame order: address LSB first, then count LSB first. After the last bit: addr = cmd[ADDR-1:0], words_left = cmd[LOAD_BITS-1:ADDR] -> READ.
- READ: 1 cycle. A = addr; CEN goes 0 at the negedge inside READ, so the SRAM samples on the posedge ending READ.
- CEN rule: CEN is negedge-registered; CEN=0 only during READ and WAIT, 1 everywhere else. WEN=1 always.
- WAIT: 1 cycle. At the posedge ending WAIT, data_reg <= PI -> SHIFT.
- SHIFT: exactly MEMORY_DATA_WIDTH cycles. SO = data_reg[0] and SO_VLD=1; data_reg shifts right each posedge.
- After the last SHIFT bit, if words_left==0 -> DONE.
- After the last SHIFT bit otherwise: addr <= addr+1 (mod 2^MEMORY_ADDR_WIDTH, wraps 0x1FF->0x000), words_left <= words_left-1 -> READ.
- Latency: first SO bit valid 2 cycles after the posedge that sampled the last command bit. Gap between words is 2 cycles (READ, WAIT) with SO_VLD=0.
- DONE: RDY=1, SO_VLD=0, SO=0. Stay in DONE while LOAD_N=0; LOAD_N sampled 1 -> IDLE (RDY drops the next cycle).
- LOAD_N toggling outside IDLE/DONE is ignored.
- A holds the last read address outside READ/WAIT; it is never driven to a write value.
- Max burst 2^CNT_WIDTH words (count field all ones = 16 words); count 0 = 1 word.

Decomposition:
- Shared package: state encodings (IDLE..DONE) and width constants. Reuse the encoding style of the loader's state constants.
- Sub-module: none required; optionally a generic shift register "serial_shift_reg" shared with the loader for both the command and data registers.

Test Plan:
- Single word: frame addr=0x005, cnt=0; SRAM[0x005]=0xA5 -> SO bits 1,0,1,0,0,1,0,1 with SO_VLD high for 8 cycles. CEN low exactly 2 cycles, then RDY=1.
- Burst with wrap: addr=0x1FE, cnt=3; SRAM holds 0x11,0x22,0x33,0x44 at 0x1FE,0x1FF,0x000,0x001 -> 4 serial words in that order. A sequence is 1FE,1FF,000,001; 2-cycle gaps with SO_VLD=0.
- Reset mid-SHIFT: assert RST during bit 3 of word 2 -> next cycle IDLE, SO_VLD=0, RDY=0; CEN=1 and WEN=1 after the next negedge. A new frame then reads correctly.
- DONE hold: keep LOAD_N=0 after completion -> RDY stays 1 and no new read. Release LOAD_N -> IDLE, RDY=0 one cycle later.
- Write safety: WEN=1 for all cycles across all scenarios. CEN=1 in IDLE, LOAD, SHIFT and DONE.
- Max burst: cnt=0xF from addr=0x000 -> exactly 16 words, addresses 0x000-0x00F, then RDY.

Source files
------------

// File: rtl/sram_readout_ctrl_pkg.sv
// Shared definitions for the serial SRAM read-back controller: default widths,
// FSM state encodings and a helper that sizes the bit timer.
package sram_readout_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_CNT_WIDTH  = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SHIFT = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Width of a down-counter that must hold max(a,b)-1.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sram_readout_ctrl.sv
// Serial SRAM read-back controller: takes an address/count frame on SI, reads
// count+1 words with an auto-incrementing address and shifts each out LSB first.
//
// state | meaning
// IDLE  | wait for LOAD_N low
// LOAD  | shift in LOAD_BITS command bits (address then count, LSB first)
// READ  | present A, CEN low from the mid-cycle negedge
// WAIT  | SRAM data settles; captured into data_q at the closing posedge
// SHIFT | drive data_q[0] on SO with SO_VLD, one bit per cycle
// DONE  | RDY high until LOAD_N is seen high
module sram_readout_ctrl
   import sram_readout_ctrl_pkg::*;
#(
   parameter int MEMORY_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEMORY_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         SI,
   input  logic                         LOAD_N,
   input  logic [MEMORY_DATA_WIDTH-1:0] PI,
   output logic                         SO,
   output logic                         SO_VLD,
   output logic                         RDY,
   output logic                         CEN,
   output logic                         WEN,
   output logic [MEMORY_ADDR_WIDTH-1:0] A
);

   localparam int LOAD_BITS = MEMORY_ADDR_WIDTH + CNT_WIDTH;
   localparam int TW        = timer_width(LOAD_BITS, MEMORY_DATA_WIDTH);
   localparam logic [TW-1:0] LOAD_LAST  = TW'(LOAD_BITS - 1);
   localparam logic [TW-1:0] SHIFT_LAST = TW'(MEMORY_DATA_WIDTH - 1);

   state_t                       state_q;
   logic [TW-1:0]                timer_q;
   logic [LOAD_BITS-2:0]         cmd_q;
   logic [MEMORY_DATA_WIDTH-1:0] data_q;
   logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
   logic [CNT_WIDTH-1:0]         words_left_q;
   logic                         so_vld_q;
   logic                         rdy_q;
   logic                         cen_q;
   logic [LOAD_BITS-1:0]         cmd_next;

   // The final command bit is consumed straight from SI so the decoded
   // address is registered on the same edge that leaves LOAD.
   assign cmd_next = {SI, cmd_q};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         cmd_q        <= '0;
         data_q       <= '0;
         addr_q       <= '0;
         words_left_q <= '0;
         so_vld_q     <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!LOAD_N) begin
                  state_q <= ST_LOAD;
                  timer_q <= LOAD_LAST;
               end
            end
            ST_LOAD: begin
               cmd_q <= cmd_next[LOAD_BITS-1:1];
               if (timer_q == '0) begin
                  addr_q       <= cmd_next[MEMORY_ADDR_WIDTH-1:0];
                  words_left_q <= cmd_next[LOAD_BITS-1:MEMORY_ADDR_WIDTH];
                  state_q      <= ST_READ;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            ST_READ: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               data_q   <= PI;
               timer_q  <= SHIFT_LAST;
               so_vld_q <= 1'b1;
               state_q  <= ST_SHIFT;
            end
            ST_SHIFT: begin
               data_q <= {1'b0, data_q[MEMORY_DATA_WIDTH-1:1]};
               if (timer_q == '0) begin
                  so_vld_q <= 1'b0;
                  if (words_left_q == '0) begin
                     rdy_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     addr_q       <= addr_q + 1'b1;
                     words_left_q <= words_left_q - 1'b1;
                     state_q      <= ST_READ;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (LOAD_N) begin
                  rdy_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // CEN changes on the falling edge so the SRAM sees a stable enable and
   // address at the posedge that closes READ.
   always_ff @(negedge CLK) begin
      if (RST) begin
         cen_q <= 1'b1;
      end else begin
         cen_q <= !((state_q == ST_READ) || (state_q == ST_WAIT));
      end
   end

   assign SO     = so_vld_q & data_q[0];
   assign SO_VLD = so_vld_q;
   assign RDY    = rdy_q;
   assign CEN    = cen_q;
   assign WEN    = 1'b1;
   assign A      = addr_q;

endmodule

// File: tb/tb_sram_readout_ctrl.sv
// Directed bench for sram_readout_ctrl: an SRAM model feeds PI, expected words
// and addresses are queued as each burst is launched and popped as they appear.
module tb_sram_readout_ctrl;

   logic       CLK;
   logic       RST;
   logic       SI;
   logic       LOAD_N;
   logic [7:0] PI;
   logic       SO;
   logic       SO_VLD;
   logic       RDY;
   logic       CEN;
   logic       WEN;
   logic [8:0] A;

   logic [7:0] mem [512];
   logic [7:0] exp_data [$];
   logic [8:0] exp_addr [$];

   int n_checks = 0;
   int n_fails  = 0;

   sram_readout_ctrl dut (
      .CLK    (CLK),
      .RST    (RST),
      .SI     (SI),
      .LOAD_N (LOAD_N),
      .PI     (PI),
      .SO     (SO),
      .SO_VLD (SO_VLD),
      .RDY    (RDY),
      .CEN    (CEN),
      .WEN    (WEN),
      .A      (A)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (CEN === 1'b0) PI <= mem[A];
   end

   task automatic tick;
      @(negedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Leaves the last command bit on SI; the caller's next tick samples it.
   task automatic send_frame(input logic [8:0] addr, input logic [3:0] cnt);
      logic [12:0] frame;
      frame  = {cnt, addr};
      LOAD_N = 1'b1;
      tick;
      tick;
      LOAD_N = 1'b0;
      tick;
      LOAD_N = 1'b1;
      for (int i = 0; i < 13; i++) begin
         SI = frame[i];
         if (i < 12) tick;
      end
   endtask

   task automatic run_burst(input logic [8:0] addr, input logic [3:0] cnt,
                            input int abort_word, input int abort_bit);
      int         n_words, cyc, bitn, wordn, gap, cen_low, first_vld, budget;
      bit         done, prev_cen;
      logic [7:0] word, ed;
      logic [8:0] ea, a_i;
      n_words = int'(cnt) + 1;
      for (int i = 0; i < n_words; i++) begin
         a_i = addr + 9'(i);
         exp_addr.push_back(a_i);
         exp_data.push_back(mem[a_i]);
      end
      send_frame(addr, cnt);
      cyc = 0; bitn = 0; wordn = 0; gap = 0; cen_low = 0; first_vld = -1;
      done = 1'b0; prev_cen = 1'b1; word = '0;
      budget = n_words * 10 + 20;
      while (!done && cyc < budget) begin
         tick;
         cyc++;
         chk("wen_high", WEN, 1);
         if (CEN === 1'b0) begin
            cen_low++;
            if (prev_cen) begin
               ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 'x;
               chk("read_addr", A, ea);
            end
         end
         prev_cen = (CEN !== 1'b0);
         if (SO_VLD === 1'b1) begin
            if (wordn == abort_word && bitn == abort_bit) begin
               RST = 1'b1;
               tick;
               chk("rst_so_vld", SO_VLD, 0);
               chk("rst_so", SO, 0);
               chk("rst_rdy", RDY, 0);
               chk("rst_cen", CEN, 1);
               chk("rst_wen", WEN, 1);
               chk("rst_addr", A, 0);
               RST = 1'b0;
               exp_addr.delete();
               exp_data.delete();
               return;
            end
            chk("cen_in_shift", CEN, 1);
            if (first_vld < 0) first_vld = cyc;
            if (bitn == 0 && wordn > 0) chk("word_gap", gap, 2);
            word[bitn] = SO;
            bitn++;
            if (bitn == 8) begin
               ed = (exp_data.size() > 0) ? exp_data.pop_front() : 'x;
               chk("data_word", word, ed);
               wordn++;
               bitn = 0;
               gap = 0;
            end
         end else begin
            gap++;
         end
         if (RDY === 1'b1) done = 1'b1;
      end
      chk("burst_done_in_budget", done, 1);
      chk("word_count", wordn, n_words);
      chk("cen_low_cycles", cen_low, 2 * n_words);
      chk("first_bit_latency", first_vld, 3);
      chk("so_in_done", SO, 0);
      chk("queues_drained", exp_addr.size() + exp_data.size(), 0);
   endtask

   initial begin
      RST = 1'b1; LOAD_N = 1'b1; SI = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
      tick;
      tick;
      chk("reset_so", SO, 0);
      chk("reset_so_vld", SO_VLD, 0);
      chk("reset_rdy", RDY, 0);
      chk("reset_addr", A, 0);
      chk("reset_cen", CEN, 1);
      chk("reset_wen", WEN, 1);
      RST = 1'b0;
      tick;

      // single word, bit order LSB first
      mem[9'h005] = 8'hA5;
      run_burst(9'h005, 4'd0, -1, -1);

      // address wrap across the top of memory
      mem[9'h1FE] = 8'h11; mem[9'h1FF] = 8'h22; mem[9'h000] = 8'h33; mem[9'h001] = 8'h44;
      run_burst(9'h1FE, 4'd3, -1, -1);

      // reset during bit 3 of the second word, then a clean frame
      run_burst(9'h1FE, 4'd3, 1, 3);
      mem[9'h100] = 8'h5A; mem[9'h101] = 8'hC3;
      run_burst(9'h100, 4'd1, -1, -1);

      // hold in DONE while LOAD_N stays low
      run_burst(9'h005, 4'd0, -1, -1);
      LOAD_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("hold_rdy", RDY, 1);
         chk("hold_cen", CEN, 1);
         chk("hold_addr", A, 9'h005);
      end
      LOAD_N = 1'b1;
      tick;
      chk("release_rdy", RDY, 0);
      chk("release_cen", CEN, 1);

      // maximum burst length
      for (int i = 0; i < 16; i++) mem[i] = 8'((i * 8'h11) ^ 8'h3C);
      run_burst(9'h000, 4'hF, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
